// File: rtl/kgp_mdu_pkg.sv
// rtl/kgp_mdu_pkg.sv - shared op and FSM state encodings for the kgp_mdu multiply/divide unit
package kgp_mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULU = 2'b00,
      OP_MUL  = 2'b01,
      OP_DIVU = 2'b10,
      OP_DIV  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

endpackage

// File: rtl/kgp_mdu_addsub.sv
// rtl/kgp_mdu_addsub.sv - WIDTH+1-bit adder/subtractor with carry out (carry=1 on subtract means x>=y)
module kgp_mdu_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0] x,
   input  logic [WIDTH:0] y,
   input  logic           sub,
   output logic [WIDTH:0] sum,
   output logic           cout
);

   logic [WIDTH:0]   y_sel;
   logic [WIDTH+1:0] full;

   assign y_sel = sub ? ~y : y;
   assign full  = {1'b0, x} + {1'b0, y_sel} + {{(WIDTH+1){1'b0}}, sub};
   assign sum   = full[WIDTH:0];
   assign cout  = full[WIDTH+1];

endmodule

// File: rtl/kgp_mdu.sv
// rtl/kgp_mdu.sv - iterative multiply/divide unit: shift-add multiply, restoring divide, sign fix at end
module kgp_mdu
   import kgp_mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dz
);

   state_e             state, next_state;
   op_e                op_q;
   logic               sa_q, sb_q;
   logic [WIDTH-1:0]   a_q, b_mag, work_hi, work_lo;
   logic [CNT_W-1:0]   cnt;

   logic               accept, last_iter, is_div, signed_in;
   logic [WIDTH:0]     as_x, as_y, as_sum;
   logic               as_cout;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic               res_dz;

   assign accept    = (state == ST_IDLE) && start;
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
   assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
   assign signed_in = (op_e'(op) == OP_MUL) || (op_e'(op) == OP_DIV);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      case (state)
         ST_IDLE: if (start) next_state = ST_RUN;
         ST_RUN: begin
            busy = 1'b1;
            if (last_iter) next_state = ST_FIX;
         end
         ST_FIX: begin
            busy       = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Divide feeds {remainder, next dividend bit}; multiply feeds the zero-extended partial product.
   always_comb begin
      as_x = is_div ? {work_hi, work_lo[WIDTH-1]} : {1'b0, work_hi};
      as_y = {1'b0, b_mag};
   end

   kgp_mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .x    (as_x),
      .y    (as_y),
      .sub  (is_div),
      .sum  (as_sum),
      .cout (as_cout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q    <= OP_MULU;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         a_q     <= '0;
         b_mag   <= '0;
         work_hi <= '0;
         work_lo <= '0;
         cnt     <= '0;
      end else if (accept) begin
         op_q    <= op_e'(op);
         sa_q    <= signed_in && a[WIDTH-1];
         sb_q    <= signed_in && b[WIDTH-1];
         a_q     <= a;
         b_mag   <= (signed_in && b[WIDTH-1]) ? -b : b;
         work_hi <= '0;
         work_lo <= (signed_in && a[WIDTH-1]) ? -a : a;
         cnt     <= '0;
      end else if (state == ST_RUN) begin
         cnt <= cnt + 1'b1;
         if (is_div) begin
            work_lo <= {work_lo[WIDTH-2:0], as_cout};
            work_hi <= as_cout ? as_sum[WIDTH-1:0] : as_x[WIDTH-1:0];
         end else if (work_lo[0]) begin
            work_hi <= as_sum[WIDTH:1];
            work_lo <= {as_sum[0], work_lo[WIDTH-1:1]};
         end else begin
            work_hi <= {1'b0, work_hi[WIDTH-1:1]};
            work_lo <= {work_hi[0], work_lo[WIDTH-1:1]};
         end
      end
   end

   // Remainder takes the dividend sign; quotient and product take the xor of both signs.
   always_comb begin
      prod     = {work_hi, work_lo};
      prod_fix = (sa_q ^ sb_q) ? -prod : prod;
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      res_dz   = 1'b0;
      if (is_div) begin
         if (b_mag == '0) begin
            res_lo = '1;
            res_hi = a_q;
            res_dz = 1'b1;
         end else begin
            res_lo = (sa_q ^ sb_q) ? -work_lo : work_lo;
            res_hi = sa_q ? -work_hi : work_hi;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done <= 1'b0;
         hi   <= '0;
         lo   <= '0;
         dz   <= 1'b0;
      end else begin
         done <= (state == ST_FIX);
         if (state == ST_FIX) begin
            hi <= res_hi;
            lo <= res_lo;
            dz <= res_dz;
         end
      end
   end

endmodule

// File: tb/tb_kgp_mdu.sv
// tb/tb_kgp_mdu.sv - directed self-checking bench for kgp_mdu at WIDTH=32
module tb_kgp_mdu;

   logic        clk = 1'b0;
   logic        rst, start, busy, done, dz;
   logic [1:0]  op;
   logic [31:0] a, b, hi, lo;
   int          n_vec = 0, n_bad = 0, cyc = 0, acc_cyc = 0;
   int          lat, n_done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   kgp_mdu #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .dz    (dz)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(output int l);
      while (done !== 1'b1 && (cyc - acc_cyc) < 60) begin
         @(posedge clk);
         #1;
      end
      l = cyc - acc_cyc;
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz);
      int l;
      launch(o, x, y);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      wait_done(l);
      chk({tag, "_lat"}, 64'(l), 64'd33);
      chk({tag, "_hi"}, 64'(hi), 64'(eh));
      chk({tag, "_lo"}, 64'(lo), 64'(el));
      chk({tag, "_dz"}, 64'(dz), 64'(edz));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      #3 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_dz", 64'(dz), 64'd0);
      @(negedge clk) rst = 1'b1;

      do_op("mulu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      do_op("mul_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      do_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      do_op("div_negb", 2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
      do_op("divu_dz", 2'b10, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b1);
      do_op("mulu_small", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
      do_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);

      launch(2'b10, 32'd1000, 32'd7);
      repeat (3) begin
         @(negedge clk);
         start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done(lat);
      chk("ign_lat", 64'(lat), 64'd33);
      chk("ign_hi", 64'(hi), 64'd6);
      chk("ign_lo", 64'(lo), 64'd142);
      chk("b2b_done_seen", 64'(done), 64'd1);
      launch(2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD);
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_done(lat);
      chk("b2b_lat", 64'(lat), 64'd33);
      chk("b2b_hi", 64'(hi), 64'd0);
      chk("b2b_lo", 64'(lo), 64'd6);
      @(posedge clk);
      #1;
      chk("done_pulse", 64'(done), 64'd0);

      launch(2'b10, 32'd12345, 32'd3);
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      chk("abort_dz", 64'(dz), 64'd0);
      @(negedge clk) rst = 1'b1;
      n_done = 0;
      repeat (45) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      chk("abort_no_done", 64'(n_done), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
      do_op("divu_post", 2'b10, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
